// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encoding and error codes shared by the ALU command sequencer.
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_NAND  = 4'd8;
  localparam logic [3:0] OP_NOR   = 4'd9;
  localparam logic [3:0] OP_XNOR  = 4'd10;
  localparam logic [3:0] OP_CMPEQ = 4'd11;
  localparam logic [3:0] OP_SHR   = 4'd12;
  localparam logic [3:0] OP_SHL   = 4'd13;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_SEND_LO = 3'd3,
    S_SEND_HI = 3'd4,
    S_ERR     = 3'd5
  } state_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DIV0    = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
endpackage

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: validates a command, pulses the ALU once, and streams the result low byte first.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int OP_MAX     = 13,
  parameter int TIMEOUT    = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic [FUN_WIDTH-1:0]    CMD_FUN,
  input  logic [DATA_WIDTH-1:0]   CMD_A,
  input  logic [DATA_WIDTH-1:0]   CMD_B,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  output logic                    ERR_VALID,
  output logic [1:0]              ERR_CODE,
  output logic                    BUSY
);
  state_t state;
  logic [3:0] cnt;
  logic [2*DATA_WIDTH-1:0] result;
  // Handshake outputs decode straight from the state register, so they change only on clock edges.
  assign CMD_READY = state == S_IDLE;
  assign BUSY      = state != S_IDLE;
  assign ALU_EN    = state == S_ISSUE;
  assign ERR_VALID = state == S_ERR;
  assign TX_VALID  = state == S_SEND_LO || state == S_SEND_HI;
  assign TX_DATA   = state == S_SEND_HI ? result[2*DATA_WIDTH-1:DATA_WIDTH] : result[DATA_WIDTH-1:0];
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      result   <= '0;
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= '0;
      ERR_CODE <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE: if (CMD_VALID) begin
          if (CMD_FUN > FUN_WIDTH'(OP_MAX)) begin
            ERR_CODE <= ERR_ILLEGAL;
            state    <= S_ERR;
          end else if (CMD_FUN == FUN_WIDTH'(OP_DIV) && CMD_B == '0) begin
            ERR_CODE <= ERR_DIV0;
            state    <= S_ERR;
          end else begin
            ALU_A   <= CMD_A;
            ALU_B   <= CMD_B;
            ALU_FUN <= CMD_FUN;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        // The counter value equals the number of WAIT cycles already spent without a result.
        S_WAIT: if (ALU_OUT_VALID) begin
          result <= ALU_OUT;
          state  <= S_SEND_LO;
        end else if (cnt == 4'(TIMEOUT - 1)) begin
          ERR_CODE <= ERR_TIMEOUT;
          state    <= S_ERR;
        end else begin
          cnt <= cnt + 4'd1;
        end
        S_SEND_LO: if (TX_READY) state <= S_SEND_HI;
        S_SEND_HI: if (TX_READY) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed scenarios against a small behavioural ALU with one-cycle registered result.
module tb_alu_cmd_sequencer;
  logic clk = 0, rst = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [3:0] cmd_fun = 0;
  logic [7:0] cmd_a = 0, cmd_b = 0;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_fun;
  logic alu_en;
  logic [15:0] alu_out = 0;
  logic alu_out_valid = 0;
  logic [7:0] tx_data;
  logic tx_valid, tx_ready = 1;
  logic err_valid, busy;
  logic [1:0] err_code;
  logic alu_mute = 0;
  int en_cnt = 0, tx_cnt = 0;
  int errors = 0, checks = 0;

  alu_cmd_sequencer dut (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_FUN(cmd_fun),
    .CMD_A(cmd_a), .CMD_B(cmd_b), .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun),
    .ALU_EN(alu_en), .ALU_OUT(alu_out), .ALU_OUT_VALID(alu_out_valid), .TX_DATA(tx_data),
    .TX_VALID(tx_valid), .TX_READY(tx_ready), .ERR_VALID(err_valid), .ERR_CODE(err_code), .BUSY(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    alu_out_valid <= 1'b0;
    if (alu_en) en_cnt <= en_cnt + 1;
    if (tx_valid) tx_cnt <= tx_cnt + 1;
    if (alu_en && !alu_mute) begin
      alu_out_valid <= 1'b1;
      case (alu_fun)
        4'd0:    alu_out <= {8'h00, alu_a} + {8'h00, alu_b};
        4'd2:    alu_out <= {8'h00, alu_a} * {8'h00, alu_b};
        4'd4:    alu_out <= {8'h00, alu_a & alu_b};
        4'd13:   alu_out <= {8'h00, alu_a} << alu_b[3:0];
        default: alu_out <= 16'h0000;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    cmd_valid = 1; cmd_fun = f; cmd_a = a; cmd_b = b;
    tick();
    cmd_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL reset_alu_en got %b want 0", alu_en); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid got %b want 0", err_valid); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d want 0", err_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({alu_a, alu_b, alu_fun, tx_data} !== 28'h0) begin errors++; $display("FAIL reset_regs got %h want 0", {alu_a, alu_b, alu_fun, tx_data}); end
  endtask

  task automatic test_add();
    tx_ready = 1;
    send(4'd0, 8'h25, 8'h13);
    checks++; if (alu_en !== 1'b1) begin errors++; $display("FAIL add_en got %b want 1", alu_en); end
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_busy got ready=%b busy=%b want 0 1", cmd_ready, busy); end
    checks++; if ({alu_a, alu_b, alu_fun} !== 20'h25130) begin errors++; $display("FAIL add_operands got %h want 25130", {alu_a, alu_b, alu_fun}); end
    tick();
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL add_en_pulse got %b want 0", alu_en); end
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h38) begin errors++; $display("FAIL add_lo got v=%b d=%h want 1 38", tx_valid, tx_data); end
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("FAIL add_hi got v=%b d=%h want 1 00", tx_valid, tx_data); end
    tick();
    checks++; if (cmd_ready !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL add_idle got ready=%b v=%b want 1 0", cmd_ready, tx_valid); end
  endtask

  task automatic test_mul_backpressure();
    tx_ready = 0;
    send(4'd2, 8'hFF, 8'hFF);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin errors++; $display("FAIL mul_hold%0d got v=%b d=%h want 1 01", i, tx_valid, tx_data); end
      if (i < 3) tick();
    end
    tx_ready = 1;
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hFE) begin errors++; $display("FAIL mul_hi got v=%b d=%h want 1 fe", tx_valid, tx_data); end
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mul_idle got %b want 1", cmd_ready); end
  endtask

  task automatic test_div0();
    int en0, tx0;
    en0 = en_cnt; tx0 = tx_cnt;
    send(4'd3, 8'h10, 8'h00);
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL div0_err got v=%b code=%0d want 1 1", err_valid, err_code); end
    tick();
    checks++; if (err_valid !== 1'b0 || err_code !== 2'd1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL div0_after got v=%b code=%0d ready=%b want 0 1 1", err_valid, err_code, cmd_ready); end
    tick();
    checks++; if (en_cnt !== en0 || tx_cnt !== tx0) begin errors++; $display("FAIL div0_side got en=%0d tx=%0d want %0d %0d", en_cnt, tx_cnt, en0, tx0); end
    checks++; if ({alu_a, alu_b, alu_fun} !== 20'hFFFF2) begin errors++; $display("FAIL div0_hold got %h want ffff2", {alu_a, alu_b, alu_fun}); end
  endtask

  task automatic test_illegal();
    int en0, tx0;
    en0 = en_cnt; tx0 = tx_cnt;
    send(4'd14, 8'h11, 8'h22);
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd2) begin errors++; $display("FAIL ill_err got v=%b code=%0d want 1 2", err_valid, err_code); end
    tick();
    checks++; if (en_cnt !== en0 || tx_cnt !== tx0) begin errors++; $display("FAIL ill_side got en=%0d tx=%0d want %0d %0d", en_cnt, tx_cnt, en0, tx0); end
    send(4'd4, 8'hF0, 8'h3C);
    tick(); tick();
    checks++; if (tx_data !== 8'h30) begin errors++; $display("FAIL and_lo got %h want 30", tx_data); end
    tick();
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL and_hi got %h want 00", tx_data); end
    tick();
    send(4'd13, 8'h81, 8'h01);
    checks++; if (alu_en !== 1'b1) begin errors++; $display("FAIL opmax_en got %b want 1", alu_en); end
    tick(); tick();
    checks++; if (tx_data !== 8'h02) begin errors++; $display("FAIL shl_lo got %h want 02", tx_data); end
    tick();
    checks++; if (tx_data !== 8'h01) begin errors++; $display("FAIL shl_hi got %h want 01", tx_data); end
    tick();
  endtask

  task automatic test_timeout();
    alu_mute = 1;
    send(4'd0, 8'h01, 8'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (err_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_wait%0d got v=%b busy=%b want 0 1", i, err_valid, busy); end
    end
    tick();
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd3) begin errors++; $display("FAIL to_err got v=%b code=%0d want 1 3", err_valid, err_code); end
    tick();
    checks++; if (cmd_ready !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL to_idle got ready=%b v=%b want 1 0", cmd_ready, tx_valid); end
    alu_mute = 0;
  endtask

  task automatic test_reset_send_lo();
    int tx0;
    tx_ready = 0;
    send(4'd0, 8'h25, 8'h13);
    tick(); tick();
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rst_lo_valid got %b want 1", tx_valid); end
    rst = 1; tick(); rst = 0;
    checks++; if (tx_valid !== 1'b0 || cmd_ready !== 1'b1 || err_code !== 2'd0) begin errors++; $display("FAIL rst_mid got v=%b ready=%b code=%0d want 0 1 0", tx_valid, cmd_ready, err_code); end
    tx0 = tx_cnt; tx_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (tx_cnt !== tx0) begin errors++; $display("FAIL rst_no_hi got %0d want %0d", tx_cnt, tx0); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    first = -1; second = -1;
    tx_ready = 1;
    cmd_valid = 1; cmd_fun = 4'd0; cmd_a = 8'h01; cmd_b = 8'h02;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (alu_en && first < 0) first = i;
      else if (alu_en && second < 0) second = i;
    end
    cmd_valid = 0;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (second - first !== 5 || first < 0) begin errors++; $display("FAIL b2b_spacing got %0d want 5", second - first); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b want 1", cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_backpressure();
    test_div0();
    test_illegal();
    test_timeout();
    test_reset_send_lo();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
